// File: rtl/floo_atop_id_alloc.sv
// Allocator for the unique IDs used by atomic (ATOP) AW transactions.
// Latency: a take or release updates busy_o/inflight_o on the next cycle;
//   alloc_avail_o/alloc_id_o are decoded combinationally from registered state.
// Backpressure: once a request sees an offer it is locked to that ID until
//   alloc_take_i, so the offered ID stays stable while the AW is stalled.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   alloc_req_i, alloc_has_r_i     atomic AW needs an ID / also returns R data
//   alloc_avail_o, alloc_id_o      offer for the current request
//   alloc_take_i                   AW handshake done, offered ID consumed
//   b_rel_valid_i, b_rel_id_i      B response releases an ID
//   r_rel_valid_i, r_rel_id_i      last R beat releases an ID
//   busy_o, inflight_o             per-ID busy vector and busy count
//   err_o                          registered protocol-error pulse
//
// Optional feature: define FLOO_ATOP_ALLOC_CHECK_EN to build the protocol
// checker driving err_o; without it err_o is tied low.

module floo_atop_id_alloc #(
  parameter int unsigned NumIds  = 4,
  parameter int unsigned IdWidth = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          alloc_req_i,
  input  logic                          alloc_has_r_i,
  output logic                          alloc_avail_o,
  output logic [IdWidth-1:0]            alloc_id_o,
  input  logic                          alloc_take_i,
  input  logic                          b_rel_valid_i,
  input  logic [IdWidth-1:0]            b_rel_id_i,
  input  logic                          r_rel_valid_i,
  input  logic [IdWidth-1:0]            r_rel_id_i,
  output logic [NumIds-1:0]             busy_o,
  output logic [$clog2(NumIds+1)-1:0]   inflight_o,
  output logic                          err_o
);

  localparam int unsigned CntWidth = $clog2(NumIds + 1);

  // Per-ID lifecycle: which responses are still outstanding.
  typedef enum logic [1:0] {
    ID_FREE    = 2'd0,
    ID_WAIT_BR = 2'd1,
    ID_WAIT_B  = 2'd2,
    ID_WAIT_R  = 2'd3
  } id_state_e;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  id_state_e           id_state_q [NumIds];
  id_state_e           id_state_d [NumIds];
  lock_state_e         lock_state_q, lock_state_d;
  logic [IdWidth-1:0]  lock_id_q, lock_id_d;
  logic [CntWidth-1:0] inflight_q, inflight_d;

  logic [NumIds-1:0]   free_vec;
  logic                any_free;
  logic [IdWidth-1:0]  first_free_id;
  logic                take_ok;
  logic [NumIds-1:0]   b_hit, r_hit, take_hit, to_free;
  logic [NumIds-1:0]   needs_b, needs_r;
  logic [CntWidth-1:0] n_freed;

  // ---------------------------------------------------------------------------
  // Offer logic (combinational from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    free_vec      = '0;
    needs_b       = '0;
    needs_r       = '0;
    any_free      = 1'b0;
    first_free_id = '0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      free_vec[i] = (id_state_q[i] == ID_FREE);
      needs_b[i]  = (id_state_q[i] == ID_WAIT_BR) || (id_state_q[i] == ID_WAIT_B);
      needs_r[i]  = (id_state_q[i] == ID_WAIT_BR) || (id_state_q[i] == ID_WAIT_R);
      // Lowest-indexed free ID wins.
      if (free_vec[i] && !any_free) begin
        first_free_id = IdWidth'(i);
        any_free      = 1'b1;
      end
    end
  end

  // A locked offer stays valid even if lower IDs free up meanwhile. The
  // locked ID itself cannot be consumed elsewhere, so it is still FREE.
  assign alloc_avail_o = (lock_state_q == LOCK_LOCKED) || any_free;
  assign alloc_id_o    = (lock_state_q == LOCK_LOCKED) ? lock_id_q : first_free_id;
  assign take_ok       = alloc_take_i && alloc_avail_o;

  // ---------------------------------------------------------------------------
  // Per-ID state update
  // ---------------------------------------------------------------------------
  // Release IDs at or above NumIds never match any index, so they drop out
  // here without a separate range check.
  always_comb begin
    for (int unsigned i = 0; i < NumIds; i++) begin
      b_hit[i]    = b_rel_valid_i && (b_rel_id_i == IdWidth'(i));
      r_hit[i]    = r_rel_valid_i && (r_rel_id_i == IdWidth'(i));
      take_hit[i] = take_ok && (alloc_id_o == IdWidth'(i));
    end
  end

  always_comb begin
    n_freed = '0;
    to_free = '0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      id_state_d[i] = id_state_q[i];
      unique case (id_state_q[i])
        ID_FREE: begin
          if (take_hit[i]) id_state_d[i] = alloc_has_r_i ? ID_WAIT_BR : ID_WAIT_B;
        end
        ID_WAIT_BR: begin
          if (b_hit[i] && r_hit[i]) id_state_d[i] = ID_FREE;
          else if (b_hit[i])        id_state_d[i] = ID_WAIT_R;
          else if (r_hit[i])        id_state_d[i] = ID_WAIT_B;
        end
        ID_WAIT_B: begin
          if (b_hit[i]) id_state_d[i] = ID_FREE;
        end
        ID_WAIT_R: begin
          if (r_hit[i]) id_state_d[i] = ID_FREE;
        end
        default: id_state_d[i] = ID_FREE;
      endcase
      to_free[i] = (id_state_q[i] != ID_FREE) && (id_state_d[i] == ID_FREE);
      n_freed    = n_freed + CntWidth'(to_free[i]);
    end
  end

  // Take always lands on a FREE ID, so the counter nets +1 against the
  // number of IDs returning to FREE in the same cycle.
  assign inflight_d = inflight_q + CntWidth'(take_ok) - n_freed;

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    lock_state_d = lock_state_q;
    lock_id_d    = lock_id_q;
    unique case (lock_state_q)
      LOCK_IDLE: begin
        if (alloc_req_i && alloc_avail_o && !alloc_take_i) begin
          lock_state_d = LOCK_LOCKED;
          lock_id_d    = alloc_id_o;
        end
      end
      LOCK_LOCKED: begin
        if (alloc_take_i) lock_state_d = LOCK_IDLE;
      end
      default: lock_state_d = LOCK_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumIds; i++) id_state_q[i] <= ID_FREE;
      lock_state_q <= LOCK_IDLE;
      lock_id_q    <= '0;
      inflight_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NumIds; i++) id_state_q[i] <= id_state_d[i];
      lock_state_q <= lock_state_d;
      lock_id_q    <= lock_id_d;
      inflight_q   <= inflight_d;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int unsigned i = 0; i < NumIds; i++) busy_o[i] = (id_state_q[i] != ID_FREE);
  end

  assign inflight_o = inflight_q;

  // ---------------------------------------------------------------------------
  // Protocol checker
  // ---------------------------------------------------------------------------
`ifdef FLOO_ATOP_ALLOC_CHECK_EN
  logic err_q, err_d;

  // A release is legal only if it hits an in-range ID still waiting for that
  // response; out-of-range IDs hit nothing and therefore flag too.
  always_comb begin
    err_d = 1'b0;
    if (alloc_take_i && !alloc_avail_o)           err_d = 1'b1;
    if (b_rel_valid_i && !(|(b_hit & needs_b)))   err_d = 1'b1;
    if (r_rel_valid_i && !(|(r_hit & needs_r)))   err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_floo_atop_id_alloc.sv
// Self-checking bench for floo_atop_id_alloc (NumIds=4, IdWidth=2).
// Directed vector table, hand-written lock/error/reset sequences, then
// randomized traffic against a response-flag reference model.

module tb_floo_atop_id_alloc;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_req, alloc_has_r, alloc_take;
  logic       alloc_avail;
  logic [1:0] alloc_id;
  logic       b_vld, r_vld;
  logic [1:0] b_id, r_id;
  logic [3:0] busy;
  logic [2:0] inflight;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  floo_atop_id_alloc #(.NumIds(4), .IdWidth(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .alloc_req_i  (alloc_req),
    .alloc_has_r_i(alloc_has_r),
    .alloc_avail_o(alloc_avail),
    .alloc_id_o   (alloc_id),
    .alloc_take_i (alloc_take),
    .b_rel_valid_i(b_vld),
    .b_rel_id_i   (b_id),
    .r_rel_valid_i(r_vld),
    .r_rel_id_i   (r_id),
    .busy_o       (busy),
    .inflight_o   (inflight),
    .err_o        (err)
  );

  // ---------------- reference model: outstanding responses per ID ----------
  bit need_b [N];
  bit need_r [N];
  bit m_locked;
  int m_lock_id;
  bit m_err;

  function automatic bit m_free(input int i);
    return !need_b[i] && !need_r[i];
  endfunction

  function automatic bit m_avail();
    bit any = 0;
    for (int i = 0; i < N; i++) if (m_free(i)) any = 1;
    return m_locked || any;
  endfunction

  function automatic int m_offer();
    if (m_locked) return m_lock_id;
    for (int i = 0; i < N; i++) if (m_free(i)) return i;
    return 0;
  endfunction

  function automatic int m_busy();
    int v = 0;
    for (int i = 0; i < N; i++) if (!m_free(i)) v = v | (1 << i);
    return v;
  endfunction

  function automatic int m_inflight();
    int c = 0;
    for (int i = 0; i < N; i++) if (!m_free(i)) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      need_b[i] = 0;
      need_r[i] = 0;
    end
    m_locked  = 0;
    m_lock_id = 0;
    m_err     = 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " busy"},     int'(busy),        m_busy());
    chk({tag, " inflight"}, int'(inflight),    m_inflight());
    chk({tag, " avail"},    int'(alloc_avail), int'(m_avail()));
    if (m_avail()) chk({tag, " id"}, int'(alloc_id), m_offer());
    chk({tag, " err"},      int'(err),         int'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic cycle(input int req, input int has_r, input int take,
                       input int bv, input int bid, input int rv, input int rid);
    bit av, e;
    int off;
    alloc_req   = (req != 0);
    alloc_has_r = (has_r != 0);
    alloc_take  = (take != 0);
    b_vld       = (bv != 0);
    b_id        = 2'(bid);
    r_vld       = (rv != 0);
    r_id        = 2'(rid);
    av  = m_avail();
    off = m_offer();
    e   = 0;
    if (take != 0 && !av) e = 1;
    if (bv != 0) begin
      if (bid >= N) e = 1;
      else if (!need_b[bid]) e = 1;
    end
    if (rv != 0) begin
      if (rid >= N) e = 1;
      else if (!need_r[rid]) e = 1;
    end
    if (bv != 0 && bid < N) need_b[bid] = 0;
    if (rv != 0 && rid < N) need_r[rid] = 0;
    if (take != 0 && av) begin
      need_b[off] = 1;
      need_r[off] = (has_r != 0);
    end
    if (!m_locked && req != 0 && av && take == 0) begin
      m_locked  = 1;
      m_lock_id = off;
    end else if (m_locked && take != 0) begin
      m_locked = 0;
    end
`ifdef FLOO_ATOP_ALLOC_CHECK_EN
    m_err = e;
`else
    m_err = 0;
`endif
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int req, has_r, take, bv, bid, rv, rid;
    int e_avail, e_id, e_inf, e_busy;
  } vec_t;

  function automatic vec_t mk(input int req, input int has_r, input int take,
                              input int bv, input int bid, input int rv, input int rid,
                              input int e_avail, input int e_id, input int e_inf,
                              input int e_busy);
    vec_t v;
    v.req = req; v.has_r = has_r; v.take = take;
    v.bv = bv; v.bid = bid; v.rv = rv; v.rid = rid;
    v.e_avail = e_avail; v.e_id = e_id; v.e_inf = e_inf; v.e_busy = e_busy;
    return v;
  endfunction

  vec_t tbl [22];
  int   exp_err;

  initial begin
    //               req hr tk bv bid rv rid  avail id inf busy
    tbl[0]  = mk(1, 0, 1, 0, 0, 0, 0,   1, 1, 1, 4'b0001);
    tbl[1]  = mk(1, 0, 1, 0, 0, 0, 0,   1, 2, 2, 4'b0011);
    tbl[2]  = mk(1, 0, 1, 0, 0, 0, 0,   1, 3, 3, 4'b0111);
    tbl[3]  = mk(1, 0, 1, 0, 0, 0, 0,   0, 0, 4, 4'b1111);
    tbl[4]  = mk(0, 0, 0, 1, 2, 0, 0,   1, 2, 3, 4'b1011);
    tbl[5]  = mk(0, 0, 0, 1, 0, 0, 0,   1, 0, 2, 4'b1010);
    tbl[6]  = mk(0, 0, 0, 1, 1, 0, 0,   1, 0, 1, 4'b1000);
    tbl[7]  = mk(0, 0, 0, 1, 3, 0, 0,   1, 0, 0, 4'b0000);
    tbl[8]  = mk(1, 1, 1, 0, 0, 0, 0,   1, 1, 1, 4'b0001);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 4'b0001);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 4'b0001);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 4'b0001);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 4'b0000);
    tbl[13] = mk(1, 1, 1, 0, 0, 0, 0,   1, 1, 1, 4'b0001);
    tbl[14] = mk(1, 1, 1, 0, 0, 0, 0,   1, 2, 2, 4'b0011);
    tbl[15] = mk(1, 1, 1, 0, 0, 0, 0,   1, 3, 3, 4'b0111);
    tbl[16] = mk(1, 1, 1, 0, 0, 0, 0,   0, 0, 4, 4'b1111);
    tbl[17] = mk(0, 0, 0, 1, 0, 1, 0,   1, 0, 3, 4'b1110);
    tbl[18] = mk(1, 0, 1, 1, 3, 1, 3,   1, 3, 3, 4'b0111);
    tbl[19] = mk(0, 0, 0, 1, 0, 0, 0,   1, 0, 2, 4'b0110);
    tbl[20] = mk(0, 0, 0, 1, 1, 1, 1,   1, 0, 1, 4'b0100);
    tbl[21] = mk(0, 0, 0, 1, 2, 1, 2,   1, 0, 0, 4'b0000);

    // ---------------- reset ----------------
    rst_n = 1'b0;
    alloc_req = 0; alloc_has_r = 0; alloc_take = 0;
    b_vld = 0; b_id = 0; r_vld = 0; r_id = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset inflight", int'(inflight), 0);
    chk("reset err", int'(err), 0);
    chk("reset avail", int'(alloc_avail), 1);
    chk("reset id", int'(alloc_id), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- vector table ----------------
    for (int i = 0; i < 22; i++) begin
      cycle(tbl[i].req, tbl[i].has_r, tbl[i].take, tbl[i].bv, tbl[i].bid,
            tbl[i].rv, tbl[i].rid);
      chk($sformatf("row%0d busy", i), int'(busy), tbl[i].e_busy);
      chk($sformatf("row%0d inflight", i), int'(inflight), tbl[i].e_inf);
      chk($sformatf("row%0d avail", i), int'(alloc_avail), tbl[i].e_avail);
      if (tbl[i].e_avail != 0)
        chk($sformatf("row%0d id", i), int'(alloc_id), tbl[i].e_id);
      chk($sformatf("row%0d err", i), int'(err), 0);
    end

    // ---------------- lock held while a lower ID frees ----------------
    cycle(1, 0, 1, 0, 0, 0, 0);              // ID 0 taken, offer 1
    cycle(1, 0, 0, 0, 0, 0, 0);              // stall 1: lock ID 1
    chk("lock stall1 id", int'(alloc_id), 1);
    cycle(1, 0, 0, 1, 0, 0, 0);              // stall 2: ID 0 frees
    chk("lock stall2 id", int'(alloc_id), 1);
    chk("lock stall2 busy", int'(busy), 0);
    cycle(1, 0, 0, 0, 0, 0, 0);              // stall 3
    chk("lock stall3 id", int'(alloc_id), 1);
    chk("lock stall3 avail", int'(alloc_avail), 1);
    cycle(1, 0, 1, 0, 0, 0, 0);              // take ID 1
    chk("lock after take id", int'(alloc_id), 0);
    chk("lock after take busy", int'(busy), 4'b0010);
    check_model("lock");
    cycle(0, 0, 0, 1, 1, 0, 0);
    check_model("lock cleanup");

    // ---------------- illegal release of a FREE ID ----------------
`ifdef FLOO_ATOP_ALLOC_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    cycle(0, 0, 0, 1, 1, 0, 0);
    chk("bad rel err", int'(err), exp_err);
    chk("bad rel busy", int'(busy), 0);
    chk("bad rel inflight", int'(inflight), 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("bad rel err clears", int'(err), 0);

    // ---------------- reset mid-operation while locked ----------------
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);              // lock ID 3
    chk("prereset busy", int'(busy), 4'b0111);
    chk("prereset id", int'(alloc_id), 3);
    #3;
    rst_n = 1'b0;
    alloc_req = 0; alloc_take = 0; alloc_has_r = 0; b_vld = 0; r_vld = 0;
    #1;
    chk("midreset busy", int'(busy), 0);
    chk("midreset inflight", int'(inflight), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("postreset avail", int'(alloc_avail), 1);
    chk("postreset id", int'(alloc_id), 0);
    chk("postreset busy", int'(busy), 0);
    chk("postreset inflight", int'(inflight), 0);
    chk("postreset err", int'(err), 0);
    @(posedge clk);
    #1;
    check_model("postreset");

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 400; c++) begin
      int req, take;
      req  = ($urandom_range(3) != 0) ? 1 : 0;
      take = (req != 0 && $urandom_range(2) == 0) ? 1 : 0;
      cycle(req, int'($urandom_range(1)), take,
            int'($urandom_range(1)), int'($urandom_range(3)),
            int'($urandom_range(1)), int'($urandom_range(3)));
      check_model($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/floo_atop_id_alloc.md
FLOO_ATOP_ID_ALLOC -- requirements
Module: floo_atop_id_alloc

Interface
REQ-001 SHALL have parameter NumIds, default 4, meaning the number of unique atomic IDs managed (1..16).
REQ-002 SHALL have parameter IdWidth, default 2, meaning the width of the ID ports; NumIds <= 2**IdWidth.
REQ-003 SHALL have port clk_i  input  1  the single clock.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port alloc_req_i  input  1  an atomic AW is presented and needs an ID.
REQ-006 SHALL have port alloc_has_r_i  input  1  the atomic also returns R data (ATOP_R_RESP); valid with alloc_req_i.
REQ-007 SHALL have port alloc_avail_o  output  1  an ID is available or locked for the current request.
REQ-008 SHALL have port alloc_id_o  output  IdWidth  the ID offered to the current request.
REQ-009 SHALL have port alloc_take_i  input  1  the AW handshake completed and the offered ID is consumed.
REQ-010 SHALL have port b_rel_valid_i  input  1  B response handshake for an atomic ID.
REQ-011 SHALL have port b_rel_id_i  input  IdWidth  ID of that B response.
REQ-012 SHALL have port r_rel_valid_i  input  1  last-beat R handshake for an atomic ID.
REQ-013 SHALL have port r_rel_id_i  input  IdWidth  ID of that R response.
REQ-014 SHALL have port busy_o  output  NumIds  per-ID "not FREE" vector.
REQ-015 SHALL have port inflight_o  output  clog2(NumIds+1)  number of non-FREE IDs.
REQ-016 SHALL have port err_o  output  1  protocol-error pulse (see Configuration).

Function
REQ-017 SHALL keep one state per ID: FREE, WAIT_BR, WAIT_B, WAIT_R.
REQ-018 SHALL, on alloc_take_i, move the offered ID FREE->WAIT_BR if alloc_has_r_i, else FREE->WAIT_B.
REQ-019 SHALL, on b release, move WAIT_BR->WAIT_R and WAIT_B->FREE.
REQ-020 SHALL, on r release, move WAIT_BR->WAIT_B and WAIT_R->FREE.
REQ-021 SHALL, on simultaneous b and r release of the same ID in WAIT_BR, move it to FREE in one cycle.
REQ-022 SHALL offer the lowest-indexed FREE ID when no ID is locked; alloc_avail_o is 1 iff a FREE ID exists or an ID is locked.
REQ-023 SHALL have a lock FSM with states IDLE and LOCKED: IDLE->LOCKED when alloc_req_i && alloc_avail_o && !alloc_take_i, latching the offered ID; LOCKED->IDLE on alloc_take_i.
REQ-024 SHALL, while LOCKED, drive the latched ID on alloc_id_o and hold alloc_avail_o at 1, irrespective of other IDs freeing.
REQ-025 SHALL make an ID freed in cycle N offerable no earlier than cycle N+1; no same-cycle release-to-alloc bypass.
REQ-026 SHALL accept alloc_take_i in the same cycle as a release of a different ID with no lost update.
REQ-027 SHALL update inflight_o as +1 on take and -1 per ID returning to FREE, netting simultaneous events; it never exceeds NumIds.
REQ-028 SHALL drive busy_o and inflight_o from registered state; alloc_avail_o and alloc_id_o are combinational from registered state.
REQ-029 SHALL ignore alloc_take_i when alloc_avail_o is 0; release IDs >= NumIds SHALL be ignored.

Reset
REQ-030 SHALL, on rst_ni low, set all IDs FREE, lock FSM IDLE, latched ID 0, inflight_o 0, busy_o 0, err_o 0.
REQ-031 SHALL, on reset mid-operation, drop all outstanding IDs; alloc_avail_o=1 and alloc_id_o=0 in the first cycle after release.

Configuration
REQ-032 SHALL, with macro FLOO_ATOP_ALLOC_CHECK_EN defined, pulse err_o for one cycle (registered) on: take with alloc_avail_o=0, b release of an ID in FREE/WAIT_R, r release of an ID in FREE/WAIT_B, or release ID >= NumIds.
REQ-033 SHALL, without FLOO_ATOP_ALLOC_CHECK_EN, tie err_o to 0 and leave the checking logic out; functional behaviour is otherwise identical.

Verification
REQ-034 SHALL cover: four takes without R (NumIds=4) -> IDs 0,1,2,3, inflight_o=4, alloc_avail_o=0; b release ID 2 -> next offer is 2 one cycle later.
REQ-035 SHALL cover: req with ID 1 offered, take stalled 3 cycles while ID 0 frees -> alloc_id_o stays 1 until take; ID 0 offered afterwards.
REQ-036 SHALL cover: take with has_r on ID 0, b then r releases 2 cycles apart -> busy_o[0] stays 1 until r, then 0; inflight_o 1->0.
REQ-037 SHALL cover: WAIT_BR ID 3 with b and r release in the same cycle, plus take of ID 0 -> ID 3 FREE, ID 0 WAIT_B, inflight_o unchanged.
REQ-038 SHALL cover: with FLOO_ATOP_ALLOC_CHECK_EN, b release of FREE ID 1 -> err_o=1 for exactly one cycle, state unchanged; without macro err_o=0.
REQ-039 SHALL cover: rst_ni low with three IDs busy and lock LOCKED -> busy_o=0, inflight_o=0, alloc_id_o=0 after release.
